// File: rtl/dsp_post_adder_acc_if.sv
// Operand, control and result bundle of the DSP post-adder/accumulator.
// Optional ovf flag exists only when ACC_SAT_EN is defined.
interface dsp_post_adder_acc_if;
  logic        ce_opmode;
  logic        ce_carryin;
  logic        ce_p;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab;
  logic [47:0] c;
  logic [47:0] pcin;
  logic        carryin;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        carryoutf;
`ifdef ACC_SAT_EN
  logic        ovf;
`endif

  modport master (
    output ce_opmode,
    output ce_carryin,
    output ce_p,
    output opmode,
    output m,
    output dab,
    output c,
    output pcin,
    output carryin,
`ifdef ACC_SAT_EN
    input  ovf,
`endif
    input  p,
    input  pcout,
    input  carryout,
    input  carryoutf
  );

  modport slave (
    input  ce_opmode,
    input  ce_carryin,
    input  ce_p,
    input  opmode,
    input  m,
    input  dab,
    input  c,
    input  pcin,
    input  carryin,
`ifdef ACC_SAT_EN
    output ovf,
`endif
    output p,
    output pcout,
    output carryout,
    output carryoutf
  );
endinterface

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1-style post-adder/accumulator: X/Z muxes, add/sub with carry, P reg.
// Define ACC_SAT_EN for signed saturation with a sticky ovf flag.
module dsp_post_adder_acc #(
  parameter int    OPMODEREG  = 1,
  parameter int    PREG       = 1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input logic           clk,
  input logic           rst,
  dsp_post_adder_acc_if.slave bus
);

  localparam bit CinOp = (CARRYINSEL == "OPMODE5");
  localparam bit OpReg = (OPMODEREG != 0);
  localparam bit PReg  = (PREG != 0);

  logic        sub_d;
  logic        sub_q;
  logic        cin_d;
  logic        cin_q;
  logic        sub_w;
  logic        cin_w;
  logic [47:0] fb_w;
  logic [47:0] x_w;
  logic [47:0] z_w;
  logic [48:0] raw_w;
  logic [47:0] sum_d;
  logic        co_d;
  logic [47:0] p_q;
  logic        co_q;
  logic [47:0] p_w;
  logic        co_w;
  logic        unused_w;

  assign unused_w = ^{bus.opmode[6], bus.opmode[4]};

  assign sub_d = bus.opmode[7];
  assign cin_d = CinOp ? bus.opmode[5] : bus.carryin;
  assign sub_w = OpReg ? sub_q : sub_d;
  assign cin_w = OpReg ? cin_q : cin_d;

  // Without a P register the feedback path reads as zero, never a loop.
  assign fb_w = PReg ? p_q : '0;

  always_comb begin
    x_w = '0;
    unique case (bus.opmode[1:0])
      2'd0: x_w = '0;
      2'd1: x_w = {12'd0, bus.m};
      2'd2: x_w = fb_w;
      2'd3: x_w = bus.dab;
      default: x_w = '0;
    endcase
  end

  always_comb begin
    z_w = '0;
    unique case (bus.opmode[3:2])
      2'd0: z_w = '0;
      2'd1: z_w = bus.pcin;
      2'd2: z_w = fb_w;
      2'd3: z_w = bus.c;
      default: z_w = '0;
    endcase
  end

  always_comb begin
    raw_w = '0;
    if (sub_w) begin
      raw_w = {1'b0, z_w}
            - ({1'b0, x_w} + {48'd0, cin_w});
    end else begin
      raw_w = {1'b0, z_w} + {1'b0, x_w}
            + {48'd0, cin_w};
    end
  end

  assign co_d = raw_w[48];

`ifdef ACC_SAT_EN
  logic [49:0] wide_w;
  logic [49:0] zs_w;
  logic [49:0] xs_w;
  logic        pos_ovf_w;
  logic        neg_ovf_w;
  logic        clamp_w;
  logic        ovf_d;
  logic        ovf_q;

  assign zs_w = {{2{z_w[47]}}, z_w};
  assign xs_w = {{2{x_w[47]}}, x_w};

  always_comb begin
    wide_w = '0;
    if (sub_w) begin
      wide_w = zs_w - xs_w - {49'd0, cin_w};
    end else begin
      wide_w = zs_w + xs_w + {49'd0, cin_w};
    end
  end

  // Out of range when bits 49..47 are not all equal.
  assign pos_ovf_w = !wide_w[49]
                   && (wide_w[48:47] != 2'b00);
  assign neg_ovf_w = wide_w[49]
                   && (wide_w[48:47] != 2'b11);
  assign clamp_w   = pos_ovf_w | neg_ovf_w;

  always_comb begin
    sum_d = wide_w[47:0];
    if (pos_ovf_w) begin
      sum_d = 48'h7FFF_FFFF_FFFF;
    end else if (neg_ovf_w) begin
      sum_d = 48'h8000_0000_0000;
    end
  end

  assign ovf_d = ovf_q | clamp_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.ce_p) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign sum_d = raw_w[47:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
      cin_q <= 1'b0;
      p_q   <= '0;
      co_q  <= 1'b0;
    end else begin
      if (bus.ce_opmode) begin
        sub_q <= sub_d;
      end
      if (bus.ce_carryin) begin
        cin_q <= cin_d;
      end
      if (bus.ce_p) begin
        p_q  <= sum_d;
        co_q <= co_d;
      end
    end
  end

  assign p_w  = PReg ? p_q : sum_d;
  assign co_w = PReg ? co_q : co_d;

  assign bus.p         = p_w;
  assign bus.pcout     = p_w;
  assign bus.carryout  = co_w;
  assign bus.carryoutf = co_w;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Self-checking bench for dsp_post_adder_acc (default parameters).
// Directed table, corner sequences, then random run against a model.
module tb_dsp_post_adder_acc;

  localparam bit CINOP = 1'b1;
  localparam bit OPREG = 1'b1;
  localparam longint M48 = (64'sd1 <<< 48) - 1;
  localparam longint M49 = (64'sd1 <<< 49) - 1;
  localparam longint H47 = 64'sd1 <<< 47;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dsp_post_adder_acc_if bus ();

  dsp_post_adder_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  op;
    logic [35:0] m;
    logic [47:0] c;
    logic [47:0] dab;
    logic        ce_p;
    logic [47:0] ep;
    logic        eco;
  } vec_t;

  vec_t tbl [16];

  longint mp;
  bit     mco;
  bit     msub;
  bit     mcin;
  bit     movf;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(string name, logic [47:0] ep, logic eco);
    chk({name, ".p"}, 64'(bus.p), 64'(ep));
    chk({name, ".pcout"}, 64'(bus.pcout), 64'(ep));
    chk({name, ".co"}, 64'(bus.carryout), 64'(eco));
    chk({name, ".cof"}, 64'(bus.carryoutf), 64'(eco));
  endtask

  // Spec-level reference: evaluate one clock edge with current inputs.
  task automatic model_step();
    longint x;
    longint z;
    longint t;
    longint xs;
    longint zs;
    longint r;
    bit cin_now;
    bit cin_use;
    bit sub_use;
    bit clamp;
    longint sum;
    cin_now = CINOP ? bus.opmode[5] : bus.carryin;
    cin_use = OPREG ? mcin : cin_now;
    sub_use = OPREG ? msub : bus.opmode[7];
    case (bus.opmode[1:0])
      2'd0: x = 0;
      2'd1: x = longint'(bus.m);
      2'd2: x = mp;
      default: x = longint'(bus.dab);
    endcase
    case (bus.opmode[3:2])
      2'd0: z = 0;
      2'd1: z = longint'(bus.pcin);
      2'd2: z = mp;
      default: z = longint'(bus.c);
    endcase
    if (sub_use) t = z - (x + longint'(cin_use));
    else t = z + x + longint'(cin_use);
    t = t & M49;
    sum = t & M48;
    clamp = 1'b0;
`ifdef ACC_SAT_EN
    xs = (x >= H47) ? x - (M48 + 1) : x;
    zs = (z >= H47) ? z - (M48 + 1) : z;
    if (sub_use) r = zs - xs - longint'(cin_use);
    else r = zs + xs + longint'(cin_use);
    if (r > H47 - 1) begin
      sum = H47 - 1;
      clamp = 1'b1;
    end else if (r < -H47) begin
      sum = H47;
      clamp = 1'b1;
    end
`else
    xs = 0;
    zs = 0;
    r = xs + zs;
`endif
    if (bus.ce_p) begin
      mp = sum;
      mco = t[48];
      movf = movf | clamp;
    end
    if (bus.ce_opmode) msub = bus.opmode[7];
    if (bus.ce_carryin) mcin = cin_now;
  endtask

  initial begin
    tbl[0]  = '{8'h09, 36'd5, 48'h0, 48'h0, 1'b1, 48'h5, 1'b0};
    tbl[1]  = '{8'h09, 36'd5, 48'h0, 48'h0, 1'b1, 48'hA, 1'b0};
    tbl[2]  = '{8'h09, 36'd5, 48'h0, 48'h0, 1'b1, 48'hF, 1'b0};
    tbl[3]  = '{8'h09, 36'd5, 48'h0, 48'h0, 1'b1, 48'h14, 1'b0};
    tbl[4]  = '{8'h2F, 36'd5, 48'h10, 48'h3, 1'b1, 48'h13, 1'b0};
    tbl[5]  = '{8'h2F, 36'd5, 48'h10, 48'h3, 1'b1, 48'h14, 1'b0};
    tbl[6]  = '{8'h8D, 36'h1, 48'h100, 48'h3, 1'b1, 48'h102, 1'b0};
    tbl[7]  = '{8'h8D, 36'h1, 48'h100, 48'h3, 1'b1, 48'hFF, 1'b0};
    tbl[8]  = '{8'h8D, 36'h101, 48'h100, 48'h3, 1'b1,
                48'hFFFF_FFFF_FFFF, 1'b1};
    tbl[9]  = '{8'h09, 36'h1, 48'h0, 48'h0, 1'b1,
                48'hFFFF_FFFF_FFFE, 1'b0};
    tbl[10] = '{8'h09, 36'h1, 48'h0, 48'h0, 1'b1,
                48'hFFFF_FFFF_FFFF, 1'b0};
    tbl[11] = '{8'h09, 36'h1, 48'h0, 48'h0, 1'b1, 48'h0, 1'b1};
    tbl[12] = '{8'h09, 36'h7, 48'h0, 48'h0, 1'b0, 48'h0, 1'b1};
    tbl[13] = '{8'h09, 36'h8, 48'h0, 48'h0, 1'b0, 48'h0, 1'b1};
    tbl[14] = '{8'h09, 36'h9, 48'h0, 48'h0, 1'b0, 48'h0, 1'b1};
    tbl[15] = '{8'h09, 36'h2, 48'h0, 48'h0, 1'b1, 48'h2, 1'b0};

    bus.ce_opmode  = 1'b0;
    bus.ce_carryin = 1'b0;
    bus.ce_p       = 1'b0;
    bus.opmode     = 8'h00;
    bus.m          = '0;
    bus.dab        = '0;
    bus.c          = '0;
    bus.pcin       = '0;
    bus.carryin    = 1'b0;

    #1;
    chk_out("reset", 48'h0, 1'b0);
`ifdef ACC_SAT_EN
    chk("reset.ovf", 64'(bus.ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    bus.ce_opmode  = 1'b1;
    bus.ce_carryin = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.opmode = tbl[i].op;
      bus.m      = tbl[i].m;
      bus.c      = tbl[i].c;
      bus.dab    = tbl[i].dab;
      bus.ce_p   = tbl[i].ce_p;
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].ep, tbl[i].eco);
    end

    // Load the largest positive value, then push it over by one.
    bus.ce_p   = 1'b1;
    bus.opmode = 8'h0C;
    bus.c      = 48'h7FFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    chk_out("load_max", 48'h7FFF_FFFF_FFFF, 1'b0);
    bus.opmode = 8'h09;
    bus.m      = 36'h1;
    @(posedge clk);
    #1;
`ifdef ACC_SAT_EN
    chk_out("sat", 48'h7FFF_FFFF_FFFF, 1'b0);
    chk("sat.ovf", 64'(bus.ovf), 64'd1);
`else
    chk_out("wrap", 48'h8000_0000_0000, 1'b0);
`endif
    bus.m = 36'h0;
    repeat (2) @(posedge clk);
    #1;
`ifdef ACC_SAT_EN
    chk("sat.ovf_sticky", 64'(bus.ovf), 64'd1);
    chk_out("sat_hold", 48'h7FFF_FFFF_FFFF, 1'b0);
`else
    chk_out("wrap_hold", 48'h8000_0000_0000, 1'b0);
`endif

    // Asynchronous reset between edges, then restart from zero.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 48'h0, 1'b0);
`ifdef ACC_SAT_EN
    chk("async_rst.ovf", 64'(bus.ovf), 64'd0);
`endif
    bus.opmode = 8'h09;
    bus.m      = 36'd5;
    bus.ce_p   = 1'b1;
    @(posedge clk);
    #1;
    chk_out("rst_over_ce", 48'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("restart", 48'h5, 1'b0);
    @(posedge clk);
    #1;
    chk_out("restart2", 48'hA, 1'b0);

    // Random run against the reference model from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    mp = 0;
    mco = 1'b0;
    msub = 1'b0;
    mcin = 1'b0;
    movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bus.opmode     = 8'($urandom());
      bus.m          = 36'({$urandom(), $urandom()});
      bus.dab        = 48'({$urandom(), $urandom()});
      bus.c          = 48'({$urandom(), $urandom()});
      bus.pcin       = 48'({$urandom(), $urandom()});
      bus.carryin    = 1'($urandom());
      bus.ce_p       = ($urandom_range(0, 3) != 0);
      bus.ce_opmode  = ($urandom_range(0, 3) != 0);
      bus.ce_carryin = ($urandom_range(0, 3) != 0);
      model_step();
      @(posedge clk);
      #1;
      chk_out($sformatf("rnd%0d", k), 48'(mp), mco);
`ifdef ACC_SAT_EN
      chk($sformatf("rnd%0d.ovf", k), 64'(bus.ovf), 64'(movf));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
